// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch requester (I,
// read-only) and a data requester (D, read/write). One transaction in flight,
// fixed memory read latency, D has priority with a starvation guard for I.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,

  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,

  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,

  output logic            busy
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam int unsigned LW = $clog2(MEM_LAT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_lat_cnt;
  logic [CW-1:0]   r_starve_cnt;
  logic            r_owner_d;
  logic            r_owner_we;
  logic            r_i_rvalid;
  logic            r_d_rvalid;
  logic [DW-1:0]   r_i_rdata;
  logic [DW-1:0]   r_d_rdata;

  logic            w_idle;
  logic            w_force_i;
  logic            w_d_gnt;
  logic            w_i_gnt;
  logic            w_last_wait;
  logic [CW-1:0]   w_starve_inc;

  // Grant arbitration: only while idle and out of reset, D first unless I is starved
  always_comb begin
    w_idle       = rst && (r_state == S_IDLE);
    w_force_i    = i_req && (r_starve_cnt == CW'(STARVE_MAX));
    w_d_gnt      = w_idle && d_req && !w_force_i;
    w_i_gnt      = w_idle && i_req && !w_d_gnt;
    w_last_wait  = (r_state == S_WAIT) && (r_lat_cnt == LW'(1));
    w_starve_inc = (r_starve_cnt == CW'(STARVE_MAX)) ? r_starve_cnt
                                                     : r_starve_cnt + CW'(1);
  end

  // Memory strobe and payload mux, driven only during a grant cycle
  always_comb begin
    m_req   = w_d_gnt || w_i_gnt;
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_d_gnt) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (w_i_gnt) begin
      m_be    = {BW{1'b1}};
      m_addr  = i_addr;
    end
  end

  // Transaction FSM: accept in IDLE, count down latency in WAIT, capture and pulse rvalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_owner_d    <= 1'b0;
      r_owner_we   <= 1'b0;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_d_gnt || w_i_gnt) begin
          r_state    <= S_WAIT;
          r_lat_cnt  <= LW'(MEM_LAT);
          r_owner_d  <= w_d_gnt;
          r_owner_we <= w_d_gnt && d_we;
        end
      end else begin
        r_lat_cnt <= r_lat_cnt - LW'(1);
        if (w_last_wait) begin
          r_state <= S_IDLE;
          if (r_owner_d) begin
            r_d_rvalid <= 1'b1;
            if (!r_owner_we) begin
              r_d_rdata <= m_rdata;
            end
          end else begin
            r_i_rvalid <= 1'b1;
            r_i_rdata  <= m_rdata;
          end
        end
      end
    end
  end

  // Starvation counter: counts D wins over a waiting I, cleared otherwise at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt) begin
      r_starve_cnt <= i_req ? w_starve_inc : '0;
    end else if (w_i_gnt) begin
      r_starve_cnt <= '0;
    end
  end

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign busy     = (r_state == S_WAIT);

endmodule
